// File: rtl/canvas_plot_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : canvas_plot_sequencer
//  Purpose  : Shares the framebuffer plot port between the canvas clear sweep
//             and the mouse brush.
//  Revision : 1.0
// ----------------------------------------------------------------------------
module canvas_plot_sequencer #(
   parameter int         WIDTH      = 160,
   parameter int         HEIGHT     = 120,
   parameter int         BRUSH      = 3,
   parameter logic [2:0] INK_COLOUR = 3'b000,
   parameter logic [2:0] BG_COLOUR  = 3'b111
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       clear_req,
   input  logic [9:0] mouse_x,
   input  logic [9:0] mouse_y,
   input  logic       left_button,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       clear_done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_BRUSH = 2'd2;

   localparam logic [7:0]        X_MAX = 8'(WIDTH - 1);
   localparam logic [6:0]        Y_MAX = 7'(HEIGHT - 1);
   localparam logic [9:0]        W_LIM = 10'(WIDTH);
   localparam logic [9:0]        H_LIM = 10'(HEIGHT);
   localparam logic [2:0]        B_MAX = 3'(BRUSH - 1);
   localparam logic signed [8:0] HALF  = 9'((BRUSH - 1) / 2);

   logic [1:0] state_q, state_d;
   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   logic [2:0] colour_q, colour_d;
   logic       plot_q, plot_d;
   logic       busy_q, busy_d;
   logic       clear_done_q, clear_done_d;
   logic       clear_pend_q, clear_pend_d;
   logic       clr_fin_q, clr_fin_d;
   logic       have_last_q, have_last_d;
   logic [7:0] last_x_q, last_x_d;
   logic [6:0] last_y_q, last_y_d;
   logic [7:0] cx_q, cx_d;
   logic [6:0] cy_q, cy_d;
   logic [7:0] clr_x_q, clr_x_d;
   logic [6:0] clr_y_q, clr_y_d;
   logic [2:0] bx_q, bx_d;
   logic [2:0] by_q, by_d;

   logic [7:0]        cx_w;
   logic [6:0]        cy_w;
   logic signed [8:0] px_w;
   logic signed [8:0] py_w;
   logic              pix_ok_w;

   assign cx_w = (mouse_x >= W_LIM) ? X_MAX : mouse_x[7:0];
   assign cy_w = (mouse_y >= H_LIM) ? Y_MAX : mouse_y[6:0];

   // Nine-bit signed sums keep off-canvas offsets negative instead of wrapping.
   assign px_w = $signed({1'b0, cx_q}) + $signed({6'b0, bx_q}) - HALF;
   assign py_w = $signed({2'b0, cy_q}) + $signed({6'b0, by_q}) - HALF;
   assign pix_ok_w = !px_w[8] && (px_w[7:0] <= X_MAX) &&
                     !py_w[8] && (py_w[7:0] <= {1'b0, Y_MAX});

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      colour_d     = colour_q;
      plot_d       = 1'b0;
      busy_d       = 1'b0;
      clear_done_d = 1'b0;
      clear_pend_d = clear_pend_q;
      clr_fin_d    = clr_fin_q;
      have_last_d  = have_last_q;
      last_x_d     = last_x_q;
      last_y_d     = last_y_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      clr_x_d      = clr_x_q;
      clr_y_d      = clr_y_q;
      bx_d         = bx_q;
      by_d         = by_q;

      case (state_q)
         S_IDLE: begin
            clear_done_d = clr_fin_q;
            clr_fin_d    = 1'b0;
            if (!left_button) have_last_d = 1'b0;
            if (clear_req || clear_pend_q) begin
               state_d      = S_CLEAR;
               clear_pend_d = 1'b0;
               clr_x_d      = 8'd0;
               clr_y_d      = 7'd0;
            end else if (left_button &&
                         (!have_last_q || cx_w != last_x_q || cy_w != last_y_q)) begin
               state_d = S_BRUSH;
               cx_d    = cx_w;
               cy_d    = cy_w;
               bx_d    = 3'd0;
               by_d    = 3'd0;
            end
         end
         S_CLEAR: begin
            x_d      = clr_x_q;
            y_d      = clr_y_q;
            colour_d = BG_COLOUR;
            plot_d   = 1'b1;
            busy_d   = 1'b1;
            if (clr_x_q == X_MAX) begin
               clr_x_d = 8'd0;
               if (clr_y_q == Y_MAX) begin
                  state_d     = S_IDLE;
                  clr_fin_d   = 1'b1;
                  have_last_d = 1'b0;
               end else begin
                  clr_y_d = clr_y_q + 7'd1;
               end
            end else begin
               clr_x_d = clr_x_q + 8'd1;
            end
         end
         S_BRUSH: begin
            x_d      = px_w[7:0];
            y_d      = py_w[6:0];
            colour_d = INK_COLOUR;
            plot_d   = pix_ok_w;
            busy_d   = 1'b1;
            if (clear_req) clear_pend_d = 1'b1;
            if (bx_q == B_MAX) begin
               bx_d = 3'd0;
               if (by_q == B_MAX) begin
                  state_d     = S_IDLE;
                  last_x_d    = cx_q;
                  last_y_d    = cy_q;
                  have_last_d = 1'b1;
               end else begin
                  by_d = by_q + 3'd1;
               end
            end else begin
               bx_d = bx_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         x_q          <= 8'd0;
         y_q          <= 7'd0;
         colour_q     <= 3'd0;
         plot_q       <= 1'b0;
         busy_q       <= 1'b0;
         clear_done_q <= 1'b0;
         clear_pend_q <= 1'b0;
         clr_fin_q    <= 1'b0;
         have_last_q  <= 1'b0;
         last_x_q     <= 8'd0;
         last_y_q     <= 7'd0;
         cx_q         <= 8'd0;
         cy_q         <= 7'd0;
         clr_x_q      <= 8'd0;
         clr_y_q      <= 7'd0;
         bx_q         <= 3'd0;
         by_q         <= 3'd0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         colour_q     <= colour_d;
         plot_q       <= plot_d;
         busy_q       <= busy_d;
         clear_done_q <= clear_done_d;
         clear_pend_q <= clear_pend_d;
         clr_fin_q    <= clr_fin_d;
         have_last_q  <= have_last_d;
         last_x_q     <= last_x_d;
         last_y_q     <= last_y_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         clr_x_q      <= clr_x_d;
         clr_y_q      <= clr_y_d;
         bx_q         <= bx_d;
         by_q         <= by_d;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign colour     = colour_q;
   assign plot       = plot_q;
   assign busy       = busy_q;
   assign clear_done = clear_done_q;

endmodule
`default_nettype wire
